// File: rtl/stream_fork_if.sv
// Handshaked stream bundle shared by the fork's input and output branches.
//   data  : payload, WIDTH bits
//   valid : beat present (driven by master)
//   last  : last beat of packet (driven by master)
//   ready : consumer can take the beat (driven by slave)
// A beat transfers on a clock edge where valid && ready.
interface stream_fork_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/stream_fork.sv
// Splits one wide stream c into two independently registered streams a and b.
// The low half of c.data goes to a and the high half goes to b. Each branch
// has a one-entry register, so a stalled consumer on one branch never holds
// back a beat already delivered to the other branch.
//
// Parameters:
//   DATA_WD  : width of each branch payload; c.data is 2*DATA_WD wide
//   HAS_LAST : 0 = every beat goes to both branches
//              1 = every beat goes to a (with last); only last beats go to b
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   c    : input stream (slave), data = {b part, a part}
//   a    : branch a output stream (master), registered data/valid/last
//   b    : branch b output stream (master), registered data/valid; last tied 0
module stream_fork #(
  parameter int unsigned DATA_WD  = 4,
  parameter bit          HAS_LAST = 1'b0
) (
  input logic          clk,
  input logic          rst,
  stream_fork_if.slave  c,
  stream_fork_if.master a,
  stream_fork_if.master b
);

  logic               need_b;
  logic               a_free;
  logic               b_free;
  logic               c_ready;
  logic               c_fire;

  logic               a_valid_q;
  logic               a_last_q;
  logic [DATA_WD-1:0] a_data_q;
  logic               b_valid_q;
  logic [DATA_WD-1:0] b_data_q;

  // c_ready looks only at branch state, the consumers' ready and c.last;
  // it must never depend on c.valid.
  always_comb begin
    need_b  = !HAS_LAST || c.last;
    a_free  = !a_valid_q || a.ready;
    b_free  = !b_valid_q || b.ready;
    c_ready = a_free && (!need_b || b_free);
    c_fire  = c.valid && c_ready;
  end

  assign c.ready = c_ready;

  // Branch a: a load while draining replaces the entry without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_data_q  <= '0;
    end else if (c_fire) begin
      a_valid_q <= 1'b1;
      a_last_q  <= HAS_LAST && c.last;
      a_data_q  <= c.data[DATA_WD-1:0];
    end else if (a.ready) begin
      a_valid_q <= 1'b0;
    end
  end

  // Branch b: non-last beats (HAS_LAST=1) leave this register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
    end else if (c_fire && need_b) begin
      b_valid_q <= 1'b1;
      b_data_q  <= c.data[2*DATA_WD-1:DATA_WD];
    end else if (b.ready) begin
      b_valid_q <= 1'b0;
    end
  end

  assign a.data  = a_data_q;
  assign a.valid = a_valid_q;
  assign a.last  = a_last_q;
  assign b.data  = b_data_q;
  assign b.valid = b_valid_q;
  assign b.last  = 1'b0;

endmodule

// File: tb/tb_stream_fork.sv
// Directed and scoreboard checks of stream_fork. Two instances (HAS_LAST=0
// and HAS_LAST=1) share the same input drive; sel picks which one is observed.
module tb_stream_fork;
  localparam int unsigned DW = 4;
  localparam int unsigned NRand = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b0;
  logic [2*DW-1:0] c_data = '0;
  logic          c_valid = 1'b0;
  logic          c_last = 1'b0;
  logic          a_ready = 1'b1;
  logic          b_ready = 1'b1;

  logic          o_c_ready, o_a_valid, o_a_last, o_b_valid;
  logic [DW-1:0] o_a_data, o_b_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  stream_fork_if #(.WIDTH(2*DW)) c0_if ();
  stream_fork_if #(.WIDTH(DW))   a0_if ();
  stream_fork_if #(.WIDTH(DW))   b0_if ();
  stream_fork_if #(.WIDTH(2*DW)) c1_if ();
  stream_fork_if #(.WIDTH(DW))   a1_if ();
  stream_fork_if #(.WIDTH(DW))   b1_if ();

  assign c0_if.data  = c_data;
  assign c0_if.valid = c_valid;
  assign c0_if.last  = c_last;
  assign a0_if.ready = a_ready;
  assign b0_if.ready = b_ready;
  assign c1_if.data  = c_data;
  assign c1_if.valid = c_valid;
  assign c1_if.last  = c_last;
  assign a1_if.ready = a_ready;
  assign b1_if.ready = b_ready;

  stream_fork #(.DATA_WD(DW), .HAS_LAST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .c(c0_if), .a(a0_if), .b(b0_if)
  );
  stream_fork #(.DATA_WD(DW), .HAS_LAST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .c(c1_if), .a(a1_if), .b(b1_if)
  );

  assign o_c_ready = sel ? c1_if.ready : c0_if.ready;
  assign o_a_valid = sel ? a1_if.valid : a0_if.valid;
  assign o_a_data  = sel ? a1_if.data  : a0_if.data;
  assign o_a_last  = sel ? a1_if.last  : a0_if.last;
  assign o_b_valid = sel ? b1_if.valid : b0_if.valid;
  assign o_b_data  = sel ? b1_if.data  : b0_if.data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    c_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input logic l);
    c_data  = d;
    c_last  = l;
    c_valid = 1'b1;
    #1;
  endtask

  task automatic run_random(input logic s);
    logic [2*DW-1:0] bd[NRand];
    logic            bl[NRand];
    logic [DW:0]     qa[$];
    logic [DW-1:0]   qb[$];
    logic [DW:0]     a_hold;
    logic [DW-1:0]   b_hold;
    logic            a_stall, b_stall, fire, a_x, b_x;
    int              idx = 0, cyc = 0, n_b_exp = 0, n_a_got = 0, n_b_got = 0;
    sel = s;
    for (int i = 0; i < int'(NRand); i++) begin
      bd[i] = 8'($urandom);
      bl[i] = s ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (i == int'(NRand) - 1) bl[i] = s;
      if (!s || bl[i]) n_b_exp++;
    end
    do_reset();
    a_stall = 1'b0;
    b_stall = 1'b0;
    while (idx < int'(NRand) || qa.size() != 0 || qb.size() != 0) begin
      if (cyc > 20000) begin
        check_eq($sformatf("rnd%0d_timeout", s), 32'(cyc), 32'(0));
        break;
      end
      if (a_stall) check_eq("rnd_a_stable", {o_a_valid, o_a_last, o_a_data}, {1'b1, a_hold});
      if (b_stall) check_eq("rnd_b_stable", {o_b_valid, o_b_data}, {1'b1, b_hold});
      a_ready = 1'($urandom);
      b_ready = 1'($urandom);
      if (idx < int'(NRand)) begin
        c_data = bd[idx]; c_last = bl[idx]; c_valid = 1'b1;
      end else begin
        c_valid = 1'b0; c_last = 1'b0;
      end
      #1;
      fire = c_valid && o_c_ready;
      a_x  = o_a_valid && a_ready;
      b_x  = o_b_valid && b_ready;
      a_stall = o_a_valid && !a_ready;
      b_stall = o_b_valid && !b_ready;
      a_hold  = {o_a_last, o_a_data};
      b_hold  = o_b_data;
      if (a_x) begin
        n_a_got++;
        if (qa.size() == 0) check_eq("rnd_a_extra", 32'(1), 32'(0));
        else check_eq($sformatf("rnd%0d_a_beat", s), {o_a_last, o_a_data}, qa.pop_front());
      end
      if (b_x) begin
        n_b_got++;
        if (qb.size() == 0) check_eq("rnd_b_extra", 32'(1), 32'(0));
        else check_eq($sformatf("rnd%0d_b_beat", s), o_b_data, qb.pop_front());
      end
      if (fire) begin
        qa.push_back({bl[idx], bd[idx][DW-1:0]});
        if (!s || bl[idx]) qb.push_back(bd[idx][2*DW-1:DW]);
        idx++;
      end
      tick();
      cyc++;
    end
    c_valid = 1'b0;
    check_eq($sformatf("rnd%0d_a_count", s), 32'(n_a_got), 32'(NRand));
    check_eq($sformatf("rnd%0d_b_count", s), 32'(n_b_got), 32'(n_b_exp));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_a_valid", o_a_valid, 0);
    check_eq("rst_b_valid", o_b_valid, 0);
    check_eq("rst_a_last", o_a_last, 0);
    check_eq("rst_a_data", o_a_data, 0);
    check_eq("rst_b_data", o_b_data, 0);

    // HAS_LAST=0: back-to-back stream, both consumers ready
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(8'(i), 1'b0);
      check_eq($sformatf("bb_c_ready%0d", i), o_c_ready, 1);
      tick();
      check_eq($sformatf("bb_a%0d", i), {o_a_valid, o_a_data}, {1'b1, 4'(i)});
      check_eq($sformatf("bb_b%0d", i), {o_b_valid, o_b_data}, {1'b1, 4'h0});
    end
    c_valid = 1'b0;
    tick();
    check_eq("bb_drain", {o_a_valid, o_b_valid}, 2'b00);

    // HAS_LAST=0: b stalled, second beat must wait for b
    b_ready = 1'b0;
    drive(8'h21, 1'b0);
    check_eq("st_c_ready0", o_c_ready, 1);
    tick();
    check_eq("st_a1", {o_a_valid, o_a_data}, {1'b1, 4'h1});
    check_eq("st_b2", {o_b_valid, o_b_data}, {1'b1, 4'h2});
    drive(8'h43, 1'b0);
    check_eq("st_c_ready1", o_c_ready, 0);
    tick();
    check_eq("st_a_drained", o_a_valid, 0);
    check_eq("st_b_hold1", {o_b_valid, o_b_data}, {1'b1, 4'h2});
    check_eq("st_c_ready2", o_c_ready, 0);
    tick();
    check_eq("st_b_hold2", {o_b_valid, o_b_data}, {1'b1, 4'h2});
    check_eq("st_a_empty2", o_a_valid, 0);
    b_ready = 1'b1;
    #1;
    check_eq("st_c_ready3", o_c_ready, 1);
    tick();
    c_valid = 1'b0;
    check_eq("st_a3", {o_a_valid, o_a_data}, {1'b1, 4'h3});
    check_eq("st_b4", {o_b_valid, o_b_data}, {1'b1, 4'h4});
    tick();
    check_eq("st_a3_once", {o_a_valid, o_b_valid}, 2'b00);

    // HAS_LAST=1: one 4-beat packet
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] pk[4];
      pk = '{8'h51, 8'h62, 8'h73, 8'hA4};
      drive(pk[k], k == 3);
      check_eq($sformatf("pk_c_ready%0d", k), o_c_ready, 1);
      tick();
      check_eq($sformatf("pk_a%0d", k), {o_a_valid, o_a_last, o_a_data},
               {1'b1, k == 3, 4'(k + 1)});
      if (k < 3) check_eq($sformatf("pk_b_idle%0d", k), o_b_valid, 0);
      else check_eq("pk_b", {o_b_valid, o_b_data}, {1'b1, 4'hA});
    end
    c_valid = 1'b0;
    tick();
    check_eq("pk_drain", {o_a_valid, o_b_valid}, 2'b00);

    // HAS_LAST=1: b full and stalled; non-last beats pass, last beat waits
    b_ready = 1'b0;
    drive(8'hB1, 1'b1);
    tick();
    check_eq("hb_b_load", {o_b_valid, o_b_data}, {1'b1, 4'hB});
    drive(8'h52, 1'b0);
    check_eq("hb_c_ready_nl0", o_c_ready, 1);
    tick();
    check_eq("hb_a2", {o_a_valid, o_a_last, o_a_data}, {2'b10, 4'h2});
    drive(8'h63, 1'b0);
    check_eq("hb_c_ready_nl1", o_c_ready, 1);
    tick();
    check_eq("hb_a3", {o_a_valid, o_a_last, o_a_data}, {2'b10, 4'h3});
    check_eq("hb_b_kept", {o_b_valid, o_b_data}, {1'b1, 4'hB});
    drive(8'hC4, 1'b1);
    check_eq("hb_c_ready_last", o_c_ready, 0);
    tick();
    check_eq("hb_a_drained", o_a_valid, 0);
    check_eq("hb_b_kept2", {o_b_valid, o_b_data}, {1'b1, 4'hB});
    b_ready = 1'b1;
    #1;
    check_eq("hb_c_ready_go", o_c_ready, 1);
    tick();
    c_valid = 1'b0;
    check_eq("hb_a4", {o_a_valid, o_a_last, o_a_data}, {2'b11, 4'h4});
    check_eq("hb_bC", {o_b_valid, o_b_data}, {1'b1, 4'hC});
    tick();

    // Reset while both branches hold stalled beats
    a_ready = 1'b0; b_ready = 1'b0;
    drive(8'hD5, 1'b1);
    tick();
    check_eq("rs_full", {o_a_valid, o_b_valid}, 2'b11);
    drive(8'hF7, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c_valid = 1'b0;
    #1;
    check_eq("rs_valid", {o_a_valid, o_b_valid, o_a_last}, 3'b000);
    check_eq("rs_c_ready", o_c_ready, 1);
    a_ready = 1'b1; b_ready = 1'b1;
    drive(8'hE6, 1'b1);
    tick();
    c_valid = 1'b0;
    check_eq("rs_fresh_a", {o_a_valid, o_a_last, o_a_data}, {2'b11, 4'h6});
    check_eq("rs_fresh_b", {o_b_valid, o_b_data}, {1'b1, 4'hE});
    tick();

    // Random backpressure scoreboard on both variants
    run_random(1'b0);
    run_random(1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
